// File: rtl/uart_rx_deframer.sv
// UART receive deframer: samples SerIn on BaudTick, walks start/data/parity/stop bits,
// and hands the assembled word plus parity/framing/overrun status to the consumer.
module uart_rx_deframer #(
    parameter int unsigned DATA_W   = 8,
    parameter logic        IDLE_LVL = 1'b1
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic              BaudTick,
    input  logic              SerIn,
    input  logic              Enable,
    input  logic [1:0]        ParityType,
    input  logic              StopBits,
    input  logic              DataAck,
    output logic [DATA_W-1:0] DataOut,
    output logic              DataValid,
    output logic              DoneFlag,
    output logic              ParityErr,
    output logic              FrameErr,
    output logic              Overrun,
    output logic              Busy
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DATA   = 3'd1;
    localparam logic [2:0] S_PARITY = 3'd2;
    localparam logic [2:0] S_STOP1  = 3'd3;
    localparam logic [2:0] S_STOP2  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shifter;
    logic [1:0]        par_type;
    logic              stop2_en;
    logic              par_err_acc;
    logic              frame_err_acc;
    logic              par_en;
    logic              par_odd;
    logic              start_seen;
    logic              last_data;

    // Frame configuration is latched at the start bit, so these only use the held copy
    assign par_en     = (par_type == 2'b01) || (par_type == 2'b10);
    assign par_odd    = (par_type == 2'b01);
    assign start_seen = BaudTick && (SerIn == ~IDLE_LVL);
    assign last_data  = (bit_cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!Enable) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_seen) begin
                        state_nxt = S_DATA;
                    end
                end
                S_DATA: begin
                    if (BaudTick && last_data) begin
                        state_nxt = par_en ? S_PARITY : S_STOP1;
                    end
                end
                S_PARITY: begin
                    if (BaudTick) begin
                        state_nxt = S_STOP1;
                    end
                end
                S_STOP1: begin
                    if (BaudTick) begin
                        state_nxt = stop2_en ? S_STOP2 : S_DONE;
                    end
                end
                S_STOP2: begin
                    if (BaudTick) begin
                        state_nxt = S_DONE;
                    end
                end
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Frame datapath: shifter, bit counter and per-frame error accumulators
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            bit_cnt       <= '0;
            shifter       <= '0;
            par_type      <= 2'b00;
            stop2_en      <= 1'b0;
            par_err_acc   <= 1'b0;
            frame_err_acc <= 1'b0;
        end else if (Enable) begin
            case (state)
                S_IDLE: begin
                    if (start_seen) begin
                        bit_cnt       <= '0;
                        par_type      <= ParityType;
                        stop2_en      <= StopBits;
                        par_err_acc   <= 1'b0;
                        frame_err_acc <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (BaudTick) begin
                        shifter <= {SerIn, shifter[DATA_W-1:1]};
                        if (bit_cnt != CNT_W'(DATA_W)) begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (BaudTick) begin
                        par_err_acc <= ((^shifter) ^ SerIn) != par_odd;
                    end
                end
                S_STOP1, S_STOP2: begin
                    if (BaudTick && (SerIn != IDLE_LVL)) begin
                        frame_err_acc <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Consumer-facing word, status and handshake; a DONE load overrides a same-cycle ack
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            DataOut   <= '0;
            DataValid <= 1'b0;
            DoneFlag  <= 1'b0;
            ParityErr <= 1'b0;
            FrameErr  <= 1'b0;
            Overrun   <= 1'b0;
            Busy      <= 1'b0;
        end else begin
            DoneFlag <= 1'b0;
            Busy     <= (state_nxt != S_IDLE);
            if (DataAck && DataValid) begin
                DataValid <= 1'b0;
                Overrun   <= 1'b0;
            end
            if (Enable && (state == S_DONE)) begin
                DoneFlag  <= 1'b1;
                DataOut   <= shifter;
                ParityErr <= par_err_acc;
                FrameErr  <= frame_err_acc;
                Overrun   <= DataValid && !DataAck;
                DataValid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench for uart_rx_deframer: table-driven frames checked through a scoreboard,
// plus hand-written overrun, ack-on-done, abort and idle-line sequences.
module tb_uart_rx_deframer;

    typedef struct {
        logic [7:0] data;
        logic [1:0] ptype;
        logic       sb;
        logic       pbit;
        logic       s1;
        logic       s2;
        logic       perr;
        logic       ferr;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       baud_tick;
    logic       ser_in;
    logic       enable;
    logic [1:0] parity_type;
    logic       stop_bits;
    logic       data_ack;
    logic [7:0] data_out;
    logic       data_valid;
    logic       done_flag;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t sb_q[$];
    vec_t vecs[9];
    logic done_prev = 1'b0;

    uart_rx_deframer #(.DATA_W(8), .IDLE_LVL(1'b1)) dut (
        .Clk        (clk),
        .ResetN     (rst_n),
        .BaudTick   (baud_tick),
        .SerIn      (ser_in),
        .Enable     (enable),
        .ParityType (parity_type),
        .StopBits   (stop_bits),
        .DataAck    (data_ack),
        .DataOut    (data_out),
        .DataValid  (data_valid),
        .DoneFlag   (done_flag),
        .ParityErr  (parity_err),
        .FrameErr   (frame_err),
        .Overrun    (overrun),
        .Busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every DoneFlag pulse must match the oldest frame still outstanding
    always @(negedge clk) begin
        if (rst_n && done_flag) begin
            check("done_pulse_width", 32'(done_prev), 32'd0);
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                vec_t e;
                e = sb_q.pop_front();
                check("data_out", 32'(data_out), 32'(e.data));
                check("parity_err", 32'(parity_err), 32'(e.perr));
                check("frame_err", 32'(frame_err), 32'(e.ferr));
                check("valid_on_done", 32'(data_valid), 32'd1);
            end
        end
        done_prev <= done_flag;
    end

    task automatic tick_bit(input logic b, input logic ack);
        @(negedge clk);
        ser_in    = b;
        baud_tick = 1'b1;
        @(negedge clk);
        baud_tick = 1'b0;
        data_ack  = ack;
        @(negedge clk);
        data_ack  = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_frame(input vec_t v, input logic ack_done);
        sb_q.push_back(v);
        parity_type = v.ptype;
        stop_bits   = v.sb;
        tick_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick_bit(v.data[i], 1'b0);
        end
        if (v.ptype == 2'b01 || v.ptype == 2'b10) begin
            tick_bit(v.pbit, 1'b0);
        end
        if (v.sb) begin
            tick_bit(v.s1, 1'b0);
            tick_bit(v.s2, ack_done);
        end else begin
            tick_bit(v.s1, ack_done);
        end
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 20 && sb_q.size() != 0; k++) begin
            @(negedge clk);
        end
        check("scoreboard_drain", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic [7:0] d, input logic [1:0] pt, input logic sb,
                                input logic pb, input logic s1, input logic s2,
                                input logic pe, input logic fe);
        vec_t v;
        v.data = d; v.ptype = pt; v.sb = sb; v.pbit = pb;
        v.s1 = s1; v.s2 = s2; v.perr = pe; v.ferr = fe;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //              data   ptype  sb    pbit  s1    s2    perr  ferr
        vecs[0] = mk(8'hA5, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[1] = mk(8'h3C, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        vecs[2] = mk(8'h81, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        vecs[3] = mk(8'h7E, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[4] = mk(8'h55, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[5] = mk(8'h0F, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        vecs[6] = mk(8'hC3, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        vecs[7] = mk(8'h12, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        vecs[8] = mk(8'hB7, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        rst_n = 1'b0; baud_tick = 1'b0; ser_in = 1'b1; enable = 1'b1;
        parity_type = 2'b00; stop_bits = 1'b0; data_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_done", 32'(done_flag), 32'd0);
        check("rst_perr", 32'(parity_err), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table frames: each is received, status checked, acked, then sticky errors checked
        for (int i = 0; i < 9; i++) begin
            send_frame(vecs[i], 1'b0);
            wait_drain();
            check("tbl_valid", 32'(data_valid), 32'd1);
            check("tbl_overrun", 32'(overrun), 32'd0);
            check("tbl_busy_idle", 32'(busy), 32'd0);
            ack_pulse();
            check("tbl_valid_acked", 32'(data_valid), 32'd0);
            check("tbl_perr_sticky", 32'(parity_err), 32'(vecs[i].perr));
            check("tbl_ferr_sticky", 32'(frame_err), 32'(vecs[i].ferr));
        end

        // Two frames with no ack: second overwrites and raises Overrun
        send_frame(mk(8'h11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0);
        send_frame(mk(8'h22, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0);
        wait_drain();
        check("ovr_valid", 32'(data_valid), 32'd1);
        check("ovr_flag", 32'(overrun), 32'd1);
        ack_pulse();
        check("ovr_valid_acked", 32'(data_valid), 32'd0);
        check("ovr_flag_acked", 32'(overrun), 32'd0);

        // Ack landing in the DONE cycle retires the old word without Overrun
        send_frame(mk(8'h33, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0);
        send_frame(mk(8'h44, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0), 1'b1);
        wait_drain();
        check("ackdone_valid", 32'(data_valid), 32'd1);
        check("ackdone_overrun", 32'(overrun), 32'd0);
        check("ackdone_data", 32'(data_out), 32'h44);
        ack_pulse();

        // Enable drop mid-frame: partial word discarded, held outputs untouched
        send_frame(mk(8'h5A, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0);
        wait_drain();
        tick_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick_bit(1'b1, 1'b0);
        check("abort_busy_mid", 32'(busy), 32'd1);
        @(negedge clk);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid_held", 32'(data_valid), 32'd1);
        check("abort_data_held", 32'(data_out), 32'h5A);
        enable = 1'b1;
        ack_pulse();

        // Reset after 4 data bits, then a clean 0x55 frame
        tick_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick_bit(1'b1, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_valid", 32'(data_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send_frame(mk(8'h55, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0);
        wait_drain();
        ack_pulse();

        // Idle line with ticks and a stray ack: nothing may start
        for (int i = 0; i < 10; i++) begin
            tick_bit(1'b1, (i == 4) ? 1'b1 : 1'b0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_valid", 32'(data_valid), 32'd0);
        end
        check("idle_no_pending", 32'(sb_q.size()), 32'd0);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
